// File: rtl/ex_stage_muldiv.sv
// ex_stage_muldiv: MIPS execute stage holding the ID/EX register, the ALU, the
// data-SRAM request logic, the HI/LO registers and an iterative mul/div engine.
// Ports: clk/rst (sync, active-high); stall vector (bit 2 EX, bit 3 MEM);
//   id_to_ex_bus in; ex_to_mem_bus, ex_to_rf_bus, ex_opcode out; data_sram_* request;
//   stallreq_for_ex raised while the mul/div engine owns the stage.
module ex_stage_muldiv #(
  parameter int ID_TO_EX_WD  = 168,
  parameter int EX_TO_MEM_WD = 77,
  parameter int EX_TO_RF_WD  = 38,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic [5:0]              ex_opcode,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

  // ---------------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------------
  logic [ID_TO_EX_WD-1:0] r_id_ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_ex <= '0;
    end else if (stall[2] && !stall[3]) begin
      // EX held but MEM moving on: insert a bubble so nothing is issued twice.
      r_id_ex <= '0;
    end else if (!stall[2]) begin
      r_id_ex <= id_to_ex_bus;
    end
  end

  logic        w_data_ram_wen;
  logic        w_div, w_divu, w_mult, w_multu;
  logic        w_mfhi, w_mflo, w_mthi, w_mtlo;
  logic [31:0] w_pc, w_inst;
  logic [11:0] w_alu_op;
  logic [2:0]  w_sel_src1;
  logic [3:0]  w_sel_src2;
  logic        w_data_ram_en;
  logic [3:0]  w_data_ram_sel;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic        w_sel_rf_res;
  logic [31:0] w_rdata1, w_rdata2;

  assign {w_data_ram_wen, w_div, w_divu, w_mult, w_multu, w_mfhi, w_mflo, w_mthi, w_mtlo,
          w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2,
          w_data_ram_en, w_data_ram_sel, w_rf_we, w_rf_waddr, w_sel_rf_res,
          w_rdata1, w_rdata2} = r_id_ex;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] w_imm_sext, w_imm_zext, w_sa;
  logic [31:0] w_src1, w_src2;
  logic [31:0] w_alu_res;

  assign w_imm_sext = {{16{w_inst[15]}}, w_inst[15:0]};
  assign w_imm_zext = {16'h0000, w_inst[15:0]};
  assign w_sa       = {27'd0, w_inst[10:6]};

  // Selects are one-hot, so an AND-OR mux is sufficient.
  assign w_src1 = ({32{w_sel_src1[0]}} & w_rdata1)
                | ({32{w_sel_src1[1]}} & w_pc)
                | ({32{w_sel_src1[2]}} & w_sa);

  assign w_src2 = ({32{w_sel_src2[0]}} & w_rdata2)
                | ({32{w_sel_src2[1]}} & w_imm_sext)
                | ({32{w_sel_src2[2]}} & 32'd8)
                | ({32{w_sel_src2[3]}} & w_imm_zext);

  logic [31:0] w_add, w_sub, w_slt, w_sltu, w_sra;

  assign w_add  = w_src1 + w_src2;
  assign w_sub  = w_src1 - w_src2;
  assign w_slt  = {31'd0, $signed(w_src1) < $signed(w_src2)};
  assign w_sltu = {31'd0, w_src1 < w_src2};
  assign w_sra  = $unsigned($signed(w_src2) >>> w_src1[4:0]);

  assign w_alu_res = ({32{w_alu_op[11]}} & w_add)
                   | ({32{w_alu_op[10]}} & w_sub)
                   | ({32{w_alu_op[9]}}  & w_slt)
                   | ({32{w_alu_op[8]}}  & w_sltu)
                   | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
                   | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
                   | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
                   | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
                   | ({32{w_alu_op[3]}}  & (w_src2 << w_src1[4:0]))
                   | ({32{w_alu_op[2]}}  & (w_src2 >> w_src1[4:0]))
                   | ({32{w_alu_op[1]}}  & w_sra)
                   | ({32{w_alu_op[0]}}  & {w_src2[15:0], 16'h0000});

  // ---------------------------------------------------------------------------
  // Data-SRAM request
  // ---------------------------------------------------------------------------
  logic [3:0]  w_wen;
  logic [31:0] w_wdata;

  always_comb begin
    w_wen   = 4'b0000;
    w_wdata = w_rdata2;
    if (w_data_ram_sel[1]) begin
      w_wdata = {2{w_rdata2[15:0]}};
    end else if (w_data_ram_sel[2]) begin
      w_wdata = {4{w_rdata2[7:0]}};
    end
    if (w_data_ram_wen) begin
      if (w_data_ram_sel[0]) begin
        w_wen = 4'b1111;
      end else if (w_data_ram_sel[1]) begin
        w_wen = 4'b0011 << w_alu_res[1:0];
      end else if (w_data_ram_sel[2]) begin
        w_wen = 4'b0001 << w_alu_res[1:0];
      end
    end
  end

  assign data_sram_en    = w_data_ram_en;
  assign data_sram_wen   = w_wen;
  assign data_sram_addr  = w_alu_res;
  assign data_sram_wdata = w_wdata;

  // ---------------------------------------------------------------------------
  // Mul/div engine
  // ---------------------------------------------------------------------------
  md_state_t   r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [63:0] r_p;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] r_opnd;   // multiplicand or divisor magnitude
  logic        r_is_div;
  logic        r_neg_q;  // negate product/quotient at the end
  logic        r_neg_r;  // negate remainder at the end
  logic        r_dz;     // divide by zero
  logic [31:0] r_rs;     // original dividend, returned as HI on divide by zero

  logic        w_md_start, w_signed;
  logic [31:0] w_mag1, w_mag2;

  assign w_md_start = w_div | w_divu | w_mult | w_multu;
  assign w_signed   = w_div | w_mult;
  assign w_mag1     = (w_signed && w_rdata1[31]) ? (~w_rdata1 + 32'd1) : w_rdata1;
  assign w_mag2     = (w_signed && w_rdata2[31]) ? (~w_rdata2 + 32'd1) : w_rdata2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    stallreq_for_ex = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_md_start) begin
          w_state_nxt     = S_BUSY;
          stallreq_for_ex = 1'b1;
        end
      end
      S_BUSY: begin
        stallreq_for_ex = 1'b1;
        if (r_cnt == 5'd31) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Stage released this cycle; instruction and HI/LO update share the edge.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // One iteration of shift-add multiply (LSB first) or restoring divide.
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_div_sh, w_div_diff;
  logic        w_div_ge;
  logic [63:0] w_div_nxt;

  assign w_mul_sum  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_nxt  = {w_mul_sum, r_p[31:1]};
  assign w_div_sh   = {r_p[63:32], r_p[31]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
  assign w_div_diff = w_div_sh - {1'b0, r_opnd};
  assign w_div_nxt  = {(w_div_ge ? w_div_diff[31:0] : w_div_sh[31:0]), r_p[30:0], w_div_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_p      <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_rs     <= '0;
    end else if (r_state == S_IDLE && w_md_start) begin
      r_cnt    <= '0;
      r_p      <= {32'd0, w_mag1};
      r_opnd   <= w_mag2;
      r_is_div <= w_div | w_divu;
      r_neg_q  <= w_signed & (w_rdata1[31] ^ w_rdata2[31]);
      r_neg_r  <= w_signed & w_rdata1[31];
      r_dz     <= (w_div | w_divu) && (w_rdata2 == 32'd0);
      r_rs     <= w_rdata1;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 5'd1;
      r_p   <= r_is_div ? w_div_nxt : w_mul_nxt;
    end
  end

  // Sign fix-up of the unsigned magnitude result.
  logic [63:0] w_prod;
  logic [31:0] w_quot, w_rem;
  logic [31:0] w_md_hi, w_md_lo;

  assign w_prod = r_neg_q ? (~r_p + 64'd1) : r_p;
  assign w_quot = r_neg_q ? (~r_p[31:0] + 32'd1) : r_p[31:0];
  assign w_rem  = r_neg_r ? (~r_p[63:32] + 32'd1) : r_p[63:32];

  always_comb begin
    w_md_hi = w_prod[63:32];
    w_md_lo = w_prod[31:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_md_hi = r_rs;
        w_md_lo = 32'hFFFF_FFFF;
      end else begin
        w_md_hi = w_rem;
        w_md_lo = w_quot;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO
  // ---------------------------------------------------------------------------
  logic [31:0] r_hi, r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_DONE) begin
      r_hi <= w_md_hi;
      r_lo <= w_md_lo;
    end else if (!stall[3]) begin
      if (w_mthi) r_hi <= w_rdata1;
      if (w_mtlo) r_lo <= w_rdata1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result, forwarding, downstream bus
  // ---------------------------------------------------------------------------
  logic [31:0] w_ex_result;

  assign w_ex_result = w_mfhi ? r_hi : (w_mflo ? r_lo : w_alu_res);

  assign ex_to_rf_bus  = {w_rf_we, w_rf_waddr, w_ex_result};
  assign ex_to_mem_bus = {w_pc, w_data_ram_en, w_data_ram_wen, w_data_ram_sel,
                          w_sel_rf_res, w_rf_we, w_rf_waddr, w_ex_result};
  assign ex_opcode     = w_inst[31:26];

  // Fields that exist on the bus but play no part in this stage.
  logic w_unused;
  assign w_unused = ^{w_inst[25:16], stall[5:4], stall[1:0], w_div_diff[32]};

endmodule

// File: tb/tb_ex_stage_muldiv.sv
module tb_ex_stage_muldiv;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   man_stall;
  logic [5:0]   stall;
  logic [167:0] bus;
  logic [76:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic [5:0]   ex_opcode;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Minimal stall controller: mul/div busy holds EX and MEM together.
  assign stall = man_stall | (stallreq_for_ex ? 6'b001111 : 6'b000000);

  ex_stage_muldiv dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .ex_opcode       (ex_opcode),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex)
  );

  localparam logic [8:0] F_WEN = 9'h100, F_DIV = 9'h080, F_DIVU = 9'h040, F_MULT = 9'h020,
                         F_MULTU = 9'h010, F_MFHI = 9'h008, F_MFLO = 9'h004,
                         F_MTHI = 9'h002, F_MTLO = 9'h001;
  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200, OP_SLTU = 12'h100,
                          OP_AND = 12'h080, OP_NOR = 12'h040, OP_OR = 12'h020, OP_XOR = 12'h010,
                          OP_SLL = 12'h008, OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;

  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  logic [37:0] rf_q[$];
  mem_exp_t    mem_q[$];
  logic [63:0] hl_q[$];

  function automatic logic [167:0] mk(input logic [8:0] fl, input logic [31:0] pc,
                                      input logic [31:0] inst, input logic [11:0] op,
                                      input logic [2:0] s1, input logic [3:0] s2,
                                      input logic en, input logic [3:0] sel, input logic we,
                                      input logic [4:0] wa, input logic [31:0] r1,
                                      input logic [31:0] r2);
    return {fl, pc, inst, op, s1, s2, en, sel, we, wa, 1'b0, r1, r2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    man_stall = 6'd0;
    bus = mk(9'd0, 32'h4, 32'h0, OP_ADD, 3'b001, 4'b0001, 1'b1, 4'b0001, 1'b1, 5'd7, 32'd1, 32'd2);
    step();
    step();
    total++; if (ex_to_rf_bus !== 38'd0) begin bad++; $display("FAIL reset_rf got=%h want=0", ex_to_rf_bus); end
    total++; if (ex_to_mem_bus !== 77'd0) begin bad++; $display("FAIL reset_mem got=%h want=0", ex_to_mem_bus); end
    total++; if (stallreq_for_ex !== 1'b0) begin bad++; $display("FAIL reset_stallreq got=%b want=0", stallreq_for_ex); end
    total++; if (data_sram_en !== 1'b0 || data_sram_wen !== 4'd0) begin
      bad++; $display("FAIL reset_sram got en=%b wen=%b want 0/0", data_sram_en, data_sram_wen);
    end
    bus = '0;
    rst = 1'b0;
    step();
  endtask

  logic [11:0] t_op  [15] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_NOR, OP_OR, OP_XOR,
                              OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_ADD, OP_ADD, OP_SLL};
  logic [2:0]  t_s1  [15] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                              3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b001, 3'b001};
  logic [3:0]  t_s2  [15] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                              4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [31:0] t_r1  [15] = '{32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'hF0F0,
                              32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h10, 32'h21};
  logic [31:0] t_r2  [15] = '{32'd7, 32'd7, 32'd1, 32'd1, 32'hFF00, 32'hFF00, 32'hFF00, 32'hFF00,
                              32'd1, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'd3};
  logic [31:0] t_inst[15] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                              32'h100, 32'h100, 32'h100, 32'h3C011234, 32'h0, 32'h2408FFFC, 32'h0};
  logic [31:0] t_exp [15] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hF000, 32'hFFFF000F, 32'hFFF0, 32'h0FF0,
                              32'h10, 32'h08000000, 32'hF8000000, 32'h12340000, 32'hBFC00008, 32'hC, 32'd6};

  task automatic test_alu();
    logic [37:0] e;
    logic [4:0]  wa;
    logic [31:0] ins;
    for (int i = 0; i < 15; i++) begin
      wa  = 5'(i + 3);
      ins = t_inst[i];
      bus = mk(9'd0, 32'hBFC00000, ins, t_op[i], t_s1[i], t_s2[i], 1'b0, 4'd0, 1'b1, wa, t_r1[i], t_r2[i]);
      rf_q.push_back({1'b1, wa, t_exp[i]});
      step();
      e = rf_q.pop_front();
      total++; if (ex_to_rf_bus !== e) begin bad++; $display("FAIL alu_%0d got=%h want=%h", i, ex_to_rf_bus, e); end
      total++; if (ex_opcode !== ins[31:26]) begin bad++; $display("FAIL opcode_%0d got=%h want=%h", i, ex_opcode, ins[31:26]); end
    end
    bus = '0;
    step();
  endtask

  task automatic test_mem();
    logic [8:0]  fl  [5] = '{F_WEN, F_WEN, F_WEN, F_WEN, 9'd0};
    logic [3:0]  sel [5] = '{4'b0100, 4'b0010, 4'b0001, 4'b0100, 4'b0001};
    logic [31:0] imm [5] = '{32'hA0000003, 32'hA4000002, 32'hAC000004, 32'hA0000001, 32'h8C000008};
    logic [31:0] r2  [5] = '{32'hAB, 32'h1234ABCD, 32'hCAFEF00D, 32'h5A, 32'h0};
    mem_exp_t    ex  [5] = '{'{1'b1, 4'b1000, 32'h103, 32'hABABABAB},
                             '{1'b1, 4'b1100, 32'h102, 32'hABCDABCD},
                             '{1'b1, 4'b1111, 32'h104, 32'hCAFEF00D},
                             '{1'b1, 4'b0010, 32'h101, 32'h5A5A5A5A},
                             '{1'b1, 4'b0000, 32'h108, 32'h0}};
    mem_exp_t e;
    for (int i = 0; i < 5; i++) begin
      bus = mk(fl[i], 32'h400, imm[i], OP_ADD, 3'b001, 4'b0010, 1'b1, sel[i], 1'b0, 5'd0, 32'h100, r2[i]);
      mem_q.push_back(ex[i]);
      step();
      e = mem_q.pop_front();
      total++;
      if (data_sram_en !== e.en || data_sram_wen !== e.wen || data_sram_addr !== e.addr ||
          (e.wen != 4'd0 && data_sram_wdata !== e.wdata)) begin
        bad++;
        $display("FAIL mem_%0d got en=%b wen=%b addr=%h wdata=%h want en=%b wen=%b addr=%h wdata=%h",
                 i, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, e.en, e.wen, e.addr, e.wdata);
      end
      if (i == 0) begin
        total++;
        if (ex_to_mem_bus !== {32'h400, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 5'd0, 32'h103}) begin
          bad++; $display("FAIL mem_bus got=%h want=%h", ex_to_mem_bus,
                          {32'h400, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 5'd0, 32'h103});
        end
      end
    end
    bus = '0;
    step();
  endtask

  // Waits out a running mul/div; returns the number of cycles stallreq was high.
  task automatic wait_busy(output int n);
    n = 0;
    while (stallreq_for_ex === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic read_hilo(input string name, input logic [63:0] e);
    bus = mk(F_MFHI, 32'h0, 32'h0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd2, 32'd0, 32'd0);
    step();
    total++; if (ex_to_rf_bus !== {1'b1, 5'd2, e[63:32]}) begin
      bad++; $display("FAIL %s_hi got=%h want=%h", name, ex_to_rf_bus[31:0], e[63:32]);
    end
    bus = mk(F_MFLO, 32'h0, 32'h0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd2, 32'd0, 32'd0);
    step();
    total++; if (ex_to_rf_bus !== {1'b1, 5'd2, e[31:0]}) begin
      bad++; $display("FAIL %s_lo got=%h want=%h", name, ex_to_rf_bus[31:0], e[31:0]);
    end
    bus = '0;
  endtask

  task automatic test_muldiv();
    logic [8:0]  fl [7] = '{F_DIVU, F_DIV, F_MULT, F_MULTU, F_DIVU, F_DIV, F_MULTU};
    logic [31:0] r1 [7] = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'd7, 32'h10000};
    logic [31:0] r2 [7] = '{32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFE, 32'h10000};
    logic [63:0] ex [7] = '{{32'd2, 32'd14}, {32'hFFFFFFFF, 32'hFFFFFFFD}, {32'hFFFFFFFF, 32'hFFFFFFFE},
                            {32'd1, 32'hFFFFFFFE}, {32'd9, 32'hFFFFFFFF}, {32'd1, 32'hFFFFFFFD},
                            {32'd1, 32'd0}};
    int n;
    for (int i = 0; i < 7; i++) begin
      bus = mk(fl[i], 32'h0, 32'h0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, r1[i], r2[i]);
      hl_q.push_back(ex[i]);
      step();
      bus = '0;
      wait_busy(n);
      total++; if (n != 33) begin bad++; $display("FAIL md_%0d_stall_cycles got=%0d want=33", i, n); end
      read_hilo($sformatf("md_%0d", i), hl_q.pop_front());
      step();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bus = mk(F_DIVU, 32'h0, 32'h0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 32'd100, 32'd7);
    step();
    bus = mk(F_MULTU, 32'h0, 32'h0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 32'd3, 32'd5);
    hl_q.push_back({32'd0, 32'd15});
    wait_busy(n);
    total++; if (n != 33) begin bad++; $display("FAIL b2b_first_cycles got=%0d want=33", n); end
    step();
    bus = '0;
    total++; if (stallreq_for_ex !== 1'b1) begin bad++; $display("FAIL b2b_second_start got=%b want=1", stallreq_for_ex); end
    wait_busy(n);
    total++; if (n != 33) begin bad++; $display("FAIL b2b_second_cycles got=%0d want=33", n); end
    read_hilo("b2b", hl_q.pop_front());
    step();
  endtask

  task automatic test_hilo_move();
    bus = mk(F_MTHI, 32'h0, 32'h0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'd0);
    step();
    bus = mk(F_MTLO, 32'h0, 32'h0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 32'h12345678, 32'd0);
    step();
    hl_q.push_back({32'hDEADBEEF, 32'h12345678});
    read_hilo("mthilo", hl_q.pop_front());
    step();
  endtask

  task automatic test_rst_mid();
    bus = mk(F_MULT, 32'h0, 32'h0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 32'd3, 32'd5);
    step();
    bus = '0;
    for (int k = 0; k < 11; k++) step();
    total++; if (stallreq_for_ex !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b want=1", stallreq_for_ex); end
    rst = 1'b1;
    step();
    total++; if (stallreq_for_ex !== 1'b0) begin bad++; $display("FAIL rstmid_stallreq got=%b want=0", stallreq_for_ex); end
    rst = 1'b0;
    hl_q.push_back(64'd0);
    read_hilo("rstmid", hl_q.pop_front());
    step();
  endtask

  task automatic test_pipe_ctrl();
    bus = mk(9'd0, 32'h0, 32'h0, OP_ADD, 3'b001, 4'b0001, 1'b1, 4'b0001, 1'b1, 5'd9, 32'd5, 32'd7);
    rf_q.push_back({1'b1, 5'd9, 32'd12});
    step();
    total++; if (ex_to_rf_bus !== rf_q[0] || data_sram_en !== 1'b1) begin
      bad++; $display("FAIL pipe_load got=%h en=%b want=%h en=1", ex_to_rf_bus, data_sram_en, rf_q[0]);
    end
    bus = mk(9'd0, 32'h0, 32'h0, OP_ADD, 3'b001, 4'b0001, 1'b0, 4'd0, 1'b1, 5'd4, 32'd1, 32'd1);
    man_stall = 6'b001100;
    step();
    total++; if (ex_to_rf_bus !== rf_q[0] || data_sram_en !== 1'b1) begin
      bad++; $display("FAIL pipe_hold got=%h en=%b want=%h en=1", ex_to_rf_bus, data_sram_en, rf_q[0]);
    end
    void'(rf_q.pop_front());
    man_stall = 6'b000100;
    step();
    total++; if (ex_to_rf_bus !== 38'd0 || data_sram_en !== 1'b0) begin
      bad++; $display("FAIL pipe_bubble got=%h en=%b want=0 en=0", ex_to_rf_bus, data_sram_en);
    end
    man_stall = 6'b000000;
    rf_q.push_back({1'b1, 5'd4, 32'd2});
    step();
    total++; if (ex_to_rf_bus !== rf_q[0]) begin
      bad++; $display("FAIL pipe_resume got=%h want=%h", ex_to_rf_bus, rf_q[0]);
    end
    void'(rf_q.pop_front());
    bus = '0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    man_stall = 6'd0;
    bus = '0;
    test_reset();
    test_alu();
    test_mem();
    test_muldiv();
    test_back_to_back();
    test_hilo_move();
    test_rst_mid();
    test_pipe_ctrl();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
